// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one RAM port between instruction fetch and data access.
// Data wins by default; a last-grant flag hands the port to instructions after a data grant.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        HIT  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

    state_t      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        last_data_q, last_data_d;
    logic [31:0] iload_q,     iload_d;
    logic [31:0] dload_q,     dload_d;
    logic        ihit_q,      ihit_d;
    logic        dhit_q,      dhit_d;
    logic        ram_ren_q,   ram_ren_d;
    logic        ram_wen_q,   ram_wen_d;
    logic [31:0] ram_addr_q,  ram_addr_d;
    logic [31:0] ram_store_q, ram_store_d;

    logic data_req;
    logic grant_data;
    logic access_done;

    assign data_req    = dREN | dWEN;
    // Data goes first unless it was also served last time and an instruction is waiting.
    assign grant_data  = data_req & ~(last_data_q & iREN);
    assign access_done = (cnt_q == WAIT_LIMIT) & ramready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        iload_d     = iload_q;
        dload_d     = dload_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (grant_data) begin
                    state_d     = DACC;
                    last_data_d = 1'b1;
                    ram_addr_d  = daddr;
                    ram_wen_d   = dWEN;
                    ram_ren_d   = ~dWEN;
                    ram_store_d = dWEN ? dstore : 32'd0;
                end else if (iREN) begin
                    state_d     = IACC;
                    last_data_d = 1'b0;
                    ram_addr_d  = iaddr;
                    ram_ren_d   = 1'b1;
                    ram_wen_d   = 1'b0;
                    ram_store_d = 32'd0;
                end
            end

            IACC: begin
                if (!iREN || access_done) begin
                    state_d     = iREN ? HIT : IDLE;
                    ihit_d      = iREN;
                    iload_d     = iREN ? ramload : iload_q;
                    cnt_d       = 4'd0;
                    ram_ren_d   = 1'b0;
                    ram_wen_d   = 1'b0;
                    ram_addr_d  = 32'd0;
                    ram_store_d = 32'd0;
                end else if (cnt_q != WAIT_LIMIT) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DACC: begin
                if (!data_req || access_done) begin
                    state_d     = data_req ? HIT : IDLE;
                    dhit_d      = data_req;
                    // Writes leave dload alone; only a completed read refreshes it.
                    if (data_req && !ram_wen_q) begin
                        dload_d = ramload;
                    end
                    cnt_d       = 4'd0;
                    ram_ren_d   = 1'b0;
                    ram_wen_d   = 1'b0;
                    ram_addr_d  = 32'd0;
                    ram_store_d = 32'd0;
                end else if (cnt_q != WAIT_LIMIT) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            HIT: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                ram_ren_d   = 1'b0;
                ram_wen_d   = 1'b0;
                ram_addr_d  = 32'd0;
                ram_store_d = 32'd0;
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                ram_ren_d   = 1'b0;
                ram_wen_d   = 1'b0;
                ram_addr_d  = 32'd0;
                ram_store_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_data_q <= 1'b0;
            iload_q     <= 32'd0;
            dload_q     <= 32'd0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_store_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
        end
    end

    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = ram_addr_q;
    assign ramstore = ram_store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int WS = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = 32'd0;
    logic        ramready = 1'b0;

    mem_arbiter #(.WAIT_STATES(WS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model state
    logic [31:0] model_iload = 32'd0;
    logic [31:0] model_dload = 32'd0;
    bit          last_was_data = 1'b0;
    bit          i_pend = 1'b0;
    bit          d_pend = 1'b0;
    bit          d_wr = 1'b0;
    bit          d_both = 1'b0;

    typedef struct {
        bit          i_ren, d_ren, d_wen, rdy;
        logic [31:0] ia, da, ds, rl;
        bit          e_ihit, e_dhit, e_rren, e_rwen;
        logic [31:0] e_raddr, e_rstore, e_iload, e_dload;
    } vec_t;

    vec_t vec [20];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        chk({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        chk({tag, "_ramaddr"}, ramaddr, 32'd0);
        chk({tag, "_ramstore"}, ramstore, 32'd0);
    endtask

    task automatic drive_reqs();
        iREN = i_pend;
        dWEN = d_pend && d_wr;
        dREN = d_pend && (!d_wr || d_both);
    endtask

    // Runs one complete access starting in an idle cycle; returns which side was granted.
    task automatic run_access(output bit grant_d);
        logic [31:0] exp_addr, exp_store, exp_load;
        bit          exp_wen, done, rdy;
        int          k;
        iaddr  = $urandom;
        daddr  = $urandom;
        dstore = $urandom;
        drive_reqs();
        grant_d       = d_pend && !(last_was_data && i_pend);
        last_was_data = grant_d;
        exp_addr  = grant_d ? daddr : iaddr;
        exp_wen   = grant_d && d_wr;
        exp_store = exp_wen ? dstore : 32'd0;
        exp_load  = 32'd0;
        tick();
        k = 0;
        done = 1'b0;
        while (!done && k < 64) begin
            chk("acc_ramREN", 32'(ramREN), 32'(!exp_wen));
            chk("acc_ramWEN", 32'(ramWEN), 32'(exp_wen));
            chk("acc_ramaddr", ramaddr, exp_addr);
            chk("acc_ramstore", ramstore, exp_store);
            chk("acc_hits", {30'd0, ihit, dhit}, 32'd0);
            rdy      = ($urandom_range(0, 3) != 0);
            ramready = rdy;
            ramload  = $urandom;
            // An access ends on the first cycle at or beyond WS wait cycles with the RAM ready.
            if (k >= WS && rdy) begin
                done     = 1'b1;
                exp_load = ramload;
            end
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            tick();
            k++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL access_timeout: got no completion, expected one within 64 cycles");
        end
        if (grant_d && !d_wr) model_dload = exp_load;
        if (!grant_d) model_iload = exp_load;
        chk("hit_ihit", 32'(ihit), 32'(!grant_d));
        chk("hit_dhit", 32'(dhit), 32'(grant_d));
        chk("hit_iload", iload, model_iload);
        chk("hit_dload", dload, model_dload);
        chk_idle_outputs("hit");
        $display("txn: grant=%s write=%0d addr=%h cycles=%0d", grant_d ? "D" : "I",
                 exp_wen, exp_addr, k);
        if (grant_d) d_pend = 1'b0;
        else         i_pend = 1'b0;
        drive_reqs();
        tick();
        chk_idle_outputs("post");
        chk("post_hits", {30'd0, ihit, dhit}, 32'd0);
    endtask

    initial begin
        bit          gd;
        int          hit_k;
        logic [31:0] held_addr;

        vec[0]  = '{1,0,0,1, 32'h100, 0, 0, 32'hDEADBEEF, 0,0,1,0, 32'h100, 0, 0, 0};
        vec[1]  = '{1,0,0,1, 32'h100, 0, 0, 32'hDEADBEEF, 0,0,1,0, 32'h100, 0, 0, 0};
        vec[2]  = '{1,0,0,1, 32'h100, 0, 0, 32'hDEADBEEF, 0,0,1,0, 32'h100, 0, 0, 0};
        vec[3]  = '{1,0,0,1, 32'h100, 0, 0, 32'hDEADBEEF, 1,0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vec[4]  = '{0,0,0,1, 0, 0, 0, 0,                  0,0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vec[5]  = '{1,0,1,1, 32'h300, 32'h200, 32'h55, 32'h11111111, 0,0,0,1, 32'h200, 32'h55, 32'hDEADBEEF, 0};
        vec[6]  = '{1,0,1,1, 32'h300, 32'h200, 32'h55, 32'h11111111, 0,0,0,1, 32'h200, 32'h55, 32'hDEADBEEF, 0};
        vec[7]  = '{1,0,1,1, 32'h300, 32'h200, 32'h55, 32'h11111111, 0,0,0,1, 32'h200, 32'h55, 32'hDEADBEEF, 0};
        vec[8]  = '{1,0,1,1, 32'h300, 32'h200, 32'h55, 32'h11111111, 0,1,0,0, 0, 0, 32'hDEADBEEF, 0};
        vec[9]  = '{1,0,0,1, 32'h300, 0, 0, 32'hCAFEF00D, 0,0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vec[10] = '{1,0,0,1, 32'h300, 0, 0, 32'hCAFEF00D, 0,0,1,0, 32'h300, 0, 32'hDEADBEEF, 0};
        vec[11] = '{1,0,0,1, 32'h300, 0, 0, 32'hCAFEF00D, 0,0,1,0, 32'h300, 0, 32'hDEADBEEF, 0};
        vec[12] = '{1,0,0,1, 32'h300, 0, 0, 32'hCAFEF00D, 0,0,1,0, 32'h300, 0, 32'hDEADBEEF, 0};
        vec[13] = '{1,0,0,1, 32'h300, 0, 0, 32'hCAFEF00D, 1,0,0,0, 0, 0, 32'hCAFEF00D, 0};
        vec[14] = '{0,0,0,1, 0, 0, 0, 0,                  0,0,0,0, 0, 0, 32'hCAFEF00D, 0};
        vec[15] = '{0,1,0,1, 0, 32'h44, 0, 32'h12345678,  0,0,1,0, 32'h44, 0, 32'hCAFEF00D, 0};
        vec[16] = '{0,1,0,1, 0, 32'h44, 0, 32'h12345678,  0,0,1,0, 32'h44, 0, 32'hCAFEF00D, 0};
        vec[17] = '{0,1,0,1, 0, 32'h44, 0, 32'h12345678,  0,0,1,0, 32'h44, 0, 32'hCAFEF00D, 0};
        vec[18] = '{0,1,0,1, 0, 32'h44, 0, 32'h12345678,  0,1,0,0, 0, 0, 32'hCAFEF00D, 32'h12345678};
        vec[19] = '{0,0,0,1, 0, 0, 0, 0,                  0,0,0,0, 0, 0, 32'hCAFEF00D, 32'h12345678};

        // Reset state, applied asynchronously
        #2 nRST = 1'b0;
        #1;
        chk_idle_outputs("reset");
        chk("reset_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("reset_iload", iload, 32'd0);
        chk("reset_dload", dload, 32'd0);
        tick();
        tick();
        nRST = 1'b1;

        // Directed vector table
        for (int r = 0; r < 20; r++) begin
            iREN = vec[r].i_ren; dREN = vec[r].d_ren; dWEN = vec[r].d_wen;
            ramready = vec[r].rdy; iaddr = vec[r].ia; daddr = vec[r].da;
            dstore = vec[r].ds; ramload = vec[r].rl;
            tick();
            chk("tbl_ihit", 32'(ihit), 32'(vec[r].e_ihit));
            chk("tbl_dhit", 32'(dhit), 32'(vec[r].e_dhit));
            chk("tbl_ramREN", 32'(ramREN), 32'(vec[r].e_rren));
            chk("tbl_ramWEN", 32'(ramWEN), 32'(vec[r].e_rwen));
            chk("tbl_ramaddr", ramaddr, vec[r].e_raddr);
            chk("tbl_ramstore", ramstore, vec[r].e_rstore);
            chk("tbl_iload", iload, vec[r].e_iload);
            chk("tbl_dload", dload, vec[r].e_dload);
            $display("vector %0d: iREN=%0d dREN=%0d dWEN=%0d -> ihit=%0d dhit=%0d ramaddr=%h",
                     r, vec[r].i_ren, vec[r].d_ren, vec[r].d_wen, ihit, dhit, ramaddr);
        end
        model_iload   = vec[19].e_iload;
        model_dload   = vec[19].e_dload;
        last_was_data = 1'b1;

        // RAM stall: ready low for 5 cycles beyond the wait states, address must stay latched
        iREN = 1'b1; iaddr = 32'h400; held_addr = 32'h400; ramready = 1'b0;
        tick();
        last_was_data = 1'b0;
        hit_k = -1;
        for (int k = 0; k < 40; k++) begin
            if (ihit) begin
                hit_k = k;
                break;
            end
            chk("stall_ramREN", 32'(ramREN), 32'd1);
            chk("stall_ramaddr", ramaddr, held_addr);
            ramready = (k >= WS + 5);
            ramload  = 32'hA5A50000 + 32'(k);
            iaddr    = $urandom;
            tick();
        end
        chk("stall_latency", 32'(hit_k), 32'(WS + 1 + 5));
        model_iload = 32'hA5A50000 + 32'(WS + 5);
        chk("stall_iload", iload, model_iload);
        $display("txn: stalled read hit after %0d access cycles", hit_k);
        iREN = 1'b0; ramready = 1'b1;
        tick();
        chk_idle_outputs("stall_post");

        // Instruction abort in the second access cycle
        iREN = 1'b1; iaddr = 32'h500; ramload = 32'h0BAD0BAD;
        tick();
        chk("iabort_c1_ramREN", 32'(ramREN), 32'd1);
        tick();
        chk("iabort_c2_ramREN", 32'(ramREN), 32'd1);
        iREN = 1'b0;
        tick();
        chk_idle_outputs("iabort");
        chk("iabort_ihit", 32'(ihit), 32'd0);
        chk("iabort_iload", iload, model_iload);
        tick();
        chk("iabort_ihit_late", 32'(ihit), 32'd0);
        $display("txn: instruction access aborted");

        // Data abort after one access cycle
        dREN = 1'b1; daddr = 32'h600;
        tick();
        chk("dabort_ramREN", 32'(ramREN), 32'd1);
        dREN = 1'b0;
        tick();
        chk_idle_outputs("dabort");
        chk("dabort_dhit", 32'(dhit), 32'd0);
        chk("dabort_dload", dload, model_dload);
        $display("txn: data access aborted");

        // Reset in the middle of a data write
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h99;
        tick();
        chk("rst_pre_ramWEN", 32'(ramWEN), 32'd1);
        tick();
        #2 nRST = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("midrst_iload", iload, 32'd0);
        chk("midrst_dload", dload, 32'd0);
        dWEN = 1'b0;
        model_iload = 32'd0; model_dload = 32'd0; last_was_data = 1'b0;
        tick();
        chk("midrst_dhit_late", 32'(dhit), 32'd0);
        nRST = 1'b1;
        tick();
        $display("txn: reset during data write");

        // Both sides requesting continuously: grants must alternate D, I, D, I
        for (int g = 0; g < 4; g++) begin
            i_pend = 1'b1; d_pend = 1'b1; d_wr = 1'b0; d_both = 1'b0;
            run_access(gd);
            chk("alt_grant", 32'(gd), 32'((g % 2) == 0));
        end
        i_pend = 1'b0; d_pend = 1'b0;
        drive_reqs();
        tick();

        // Random traffic against the model
        for (int t = 0; t < 200; t++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) i_pend = 1'b1;
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1'b1;
                d_wr   = $urandom_range(0, 1) == 1;
                d_both = $urandom_range(0, 1) == 1;
            end
            if (!i_pend && !d_pend) i_pend = 1'b1;
            run_access(gd);
            if ($urandom_range(0, 7) == 0) begin
                drive_reqs();
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
                tick();
                chk_idle_outputs("gap");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
